// File: rtl/mux_bus_arbiter_if.sv
// Bundle between the two requesters and the shared operand/bus mux arbiter.
//
// Handshake: reqX is a request that doubles as a per-beat valid, and gntX
// plays the role of ready. A beat moves on every rising edge where reqX and
// gntX are both high. The requester must hold dataINX/lastX stable while
// reqX=1 and gntX=0. lastX only has meaning on a beat. validOUT marks the
// cycle after a beat, when dataOUT carries that beat's word.
interface mux_bus_arbiter_if #(
  parameter int WIDTH = 9
);
  logic             reqA;
  logic [WIDTH-1:0] dataINA;
  logic             lastA;
  logic             reqB;
  logic [WIDTH-1:0] dataINB;
  logic             lastB;
  logic             gntA;
  logic             gntB;
  logic             sel;
  logic [WIDTH-1:0] dataOUT;
  logic             validOUT;

  // Requester side: drives requests and data, observes grants and output.
  modport master (
    output reqA, dataINA, lastA, reqB, dataINB, lastB,
    input  gntA, gntB, sel, dataOUT, validOUT
  );

  // Arbiter side.
  modport slave (
    input  reqA, dataINA, lastA, reqB, dataINB, lastB,
    output gntA, gntB, sel, dataOUT, validOUT
  );
endinterface

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared 2:1 operand/bus mux.
// Grants go to A or B. Each grant lasts at most MAX_HOLD beats, so neither
// side can starve the other. The selected word is registered onto dataOUT
// with a validOUT strobe one cycle after its beat.
module mux_bus_arbiter #(
  parameter int WIDTH    = 9,
  parameter int MAX_HOLD = 8   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  mux_bus_arbiter_if.slave  bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } state_t;

  state_t           state;
  logic             ptr_b;      // 0: A has priority on contention, 1: B
  logic [3:0]       cnt;        // beats already taken in the current grant
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;

  logic             cur_req;
  logic             cur_last;
  logic [WIDTH-1:0] cur_data;
  logic             oth_req;
  logic             hit_max;
  logic             grant_end;

  // Outputs are a pure decode of registered state; no path from req.
  assign bus.gntA     = (state == BUSY_A);
  assign bus.gntB     = (state == BUSY_B);
  assign bus.sel      = (state == BUSY_B);
  assign bus.dataOUT  = dout_q;
  assign bus.validOUT = valid_q;
  assign state_dbg    = state;

  // Look at the side that currently owns the bus and decide whether its
  // grant ends at this edge. Only meaningful while in a BUSY state.
  always_comb begin
    cur_req   = bus.reqA;
    cur_last  = bus.lastA;
    cur_data  = bus.dataINA;
    oth_req   = bus.reqB;
    if (state == BUSY_B) begin
      cur_req  = bus.reqB;
      cur_last = bus.lastB;
      cur_data = bus.dataINB;
      oth_req  = bus.reqA;
    end
    // cnt < MAX_HOLD <= 15 inside a grant, so cnt+1 cannot wrap.
    hit_max   = ((cnt + 4'd1) == 4'(MAX_HOLD));
    // A dropped request ends the grant on its own, so last/max only need
    // to be considered on an actual beat.
    grant_end = !cur_req || cur_last || hit_max;
  end

  // Arbitration FSM, beat counter, priority pointer and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr_b   <= 1'b0;
      cnt     <= 4'd0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          cnt     <= 4'd0;
          // The pointer is left alone here; it only moves when a grant ends.
          if (bus.reqA && bus.reqB) state <= ptr_b ? BUSY_B : BUSY_A;
          else if (bus.reqA)        state <= BUSY_A;
          else if (bus.reqB)        state <= BUSY_B;
        end
        BUSY_A, BUSY_B: begin
          if (cur_req) begin
            dout_q  <= cur_data;
            valid_q <= 1'b1;
          end else begin
            valid_q <= 1'b0;
          end
          if (grant_end) begin
            // Exactly one pointer flip per grant end, even when last and
            // max hold coincide.
            ptr_b <= (state == BUSY_A);
            cnt   <= 4'd0;
            if (oth_req)      state <= (state == BUSY_A) ? BUSY_B : BUSY_A;
            else if (cur_req) state <= state;  // ended by last/max: fresh grant
            else              state <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          cnt     <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Directed bench for mux_bus_arbiter: one instance with MAX_HOLD=8 and a
// second with MAX_HOLD=1 for the strict-alternation case.
module tb_mux_bus_arbiter;

  localparam int W = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_bus_arbiter_if #(.WIDTH(W)) bus8 ();
  mux_bus_arbiter_if #(.WIDTH(W)) bus1 ();
  logic [1:0] st8;
  logic [1:0] st1;

  mux_bus_arbiter #(.WIDTH(W), .MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8.slave), .state_dbg(st8)
  );
  mux_bus_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .state_dbg(st1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; inputs changed after this
  // call apply to the cycle that has just begun.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus8.reqA = 1'b0; bus8.lastA = 1'b0; bus8.dataINA = '0;
    bus8.reqB = 1'b0; bus8.lastB = 1'b0; bus8.dataINB = '0;
    bus1.reqA = 1'b0; bus1.lastA = 1'b0; bus1.dataINA = '0;
    bus1.reqB = 1'b0; bus1.lastB = 1'b0; bus1.dataINB = '0;
  endtask

  // Leaves the bench at a falling edge with reset released; that half
  // cycle is "cycle 0".
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();

    // ---- async reset in the middle of a B burst ----
    do_reset();
    check("rst_state", {14'd0, st8}, 16'd0);
    check("rst_valid", {15'd0, bus8.validOUT}, 16'd0);
    bus8.reqB = 1'b1; bus8.dataINB = 9'h0C3;
    step();                                        // cycle 1
    check("rb_gntB_c1", {15'd0, bus8.gntB}, 16'd1);
    step();                                        // cycle 2
    check("rb_dout_c2", {7'd0, bus8.dataOUT}, 16'h0C3);
    check("rb_valid_c2", {15'd0, bus8.validOUT}, 16'd1);
    #3 rst = 1'b1;                                 // no clock edge before the check
    #1;
    check("rb_async_gntB", {15'd0, bus8.gntB}, 16'd0);
    check("rb_async_sel", {15'd0, bus8.sel}, 16'd0);
    check("rb_async_valid", {15'd0, bus8.validOUT}, 16'd0);
    check("rb_async_dout", {7'd0, bus8.dataOUT}, 16'd0);

    // ---- contention, MAX_HOLD=8, A first after reset ----
    bus8.reqA = 1'b1; bus8.dataINA = 9'h011;
    bus8.reqB = 1'b1; bus8.dataINB = 9'h122;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      logic side;
      logic prev_side;
      step();
      side      = ((k - 1) / 8) % 2 == 1;
      prev_side = ((k - 2) / 8) % 2 == 1;
      check("ct_gntA", {15'd0, bus8.gntA}, {15'd0, ~side});
      check("ct_gntB", {15'd0, bus8.gntB}, {15'd0, side});
      check("ct_sel", {15'd0, bus8.sel}, {15'd0, side});
      if (k >= 2) begin
        check("ct_valid", {15'd0, bus8.validOUT}, 16'd1);
        check("ct_dout", {7'd0, bus8.dataOUT}, prev_side ? 16'h122 : 16'h011);
      end
    end

    // ---- single requester A, three beats, last on the third ----
    do_reset();
    bus8.reqA = 1'b1; bus8.dataINA = 9'h1A5;
    step();                                        // c1: beat 0x1A5
    check("sg_gntA_c1", {15'd0, bus8.gntA}, 16'd1);
    check("sg_valid_c1", {15'd0, bus8.validOUT}, 16'd0);
    step();                                        // c2
    check("sg_gntA_c2", {15'd0, bus8.gntA}, 16'd1);
    check("sg_dout_c2", {7'd0, bus8.dataOUT}, 16'h1A5);
    check("sg_valid_c2", {15'd0, bus8.validOUT}, 16'd1);
    bus8.dataINA = 9'h0FF;
    step();                                        // c3
    check("sg_gntA_c3", {15'd0, bus8.gntA}, 16'd1);
    check("sg_dout_c3", {7'd0, bus8.dataOUT}, 16'h0FF);
    bus8.dataINA = 9'h003; bus8.lastA = 1'b1;
    step();                                        // c4: re-granted, A still requesting at last
    check("sg_dout_c4", {7'd0, bus8.dataOUT}, 16'h003);
    check("sg_valid_c4", {15'd0, bus8.validOUT}, 16'd1);
    check("sg_gntA_c4", {15'd0, bus8.gntA}, 16'd1);
    bus8.reqA = 1'b0; bus8.lastA = 1'b0;
    step();                                        // c5: released
    check("sg_idle_c5", {14'd0, st8}, 16'd0);
    check("sg_valid_c5", {15'd0, bus8.validOUT}, 16'd0);
    bus8.reqA = 1'b1; bus8.reqB = 1'b1;
    step();                                        // pointer now names B
    check("sg_ptr_gntB", {15'd0, bus8.gntB}, 16'd1);

    // ---- early release of B after two beats ----
    do_reset();
    bus8.reqB = 1'b1; bus8.dataINB = 9'h0B1;
    step();                                        // c1
    check("er_gntB_c1", {15'd0, bus8.gntB}, 16'd1);
    step();                                        // c2
    step();                                        // c3
    check("er_gntB_c3", {15'd0, bus8.gntB}, 16'd1);
    check("er_dout_c3", {7'd0, bus8.dataOUT}, 16'h0B1);
    bus8.reqB = 1'b0; bus8.reqA = 1'b1; bus8.dataINA = 9'h0A1;
    step();                                        // c4
    check("er_gntA_c4", {15'd0, bus8.gntA}, 16'd1);
    check("er_valid_c4", {15'd0, bus8.validOUT}, 16'd0);
    bus8.reqA = 1'b0; bus8.reqB = 1'b1;
    step();                                        // c5
    bus8.reqA = 1'b1;
    // B must now get a full eight beats: its earlier count is gone.
    for (int k = 5; k <= 13; k++) begin
      if (k > 5) step();
      check("er_gntB_fresh", {15'd0, bus8.gntB}, (k <= 12) ? 16'd1 : 16'd0);
      check("er_gntA_after", {15'd0, bus8.gntA}, (k <= 12) ? 16'd0 : 16'd1);
    end

    // ---- last with no competitor: immediate fresh re-grant ----
    do_reset();
    bus8.reqA = 1'b1; bus8.dataINA = 9'h033;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("ln_gntA", {15'd0, bus8.gntA}, (k <= 11) ? 16'd1 : 16'd0);
      check("ln_gntB", {15'd0, bus8.gntB}, (k <= 11) ? 16'd0 : 16'd1);
      if (k == 3) bus8.lastA = 1'b1;
      if (k == 4) begin
        bus8.lastA = 1'b0;
        bus8.reqB  = 1'b1;
      end
    end

    // ---- MAX_HOLD=1: strict alternation ----
    do_reset();
    bus1.reqA = 1'b1; bus1.dataINA = 9'h055;
    bus1.reqB = 1'b1; bus1.dataINB = 9'h1AA;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("mh1_sel", {15'd0, bus1.sel}, {15'd0, 1'((k - 1) % 2)});
      if (k >= 2) begin
        check("mh1_valid", {15'd0, bus1.validOUT}, 16'd1);
        check("mh1_dout", {7'd0, bus1.dataOUT}, ((k - 2) % 2 == 1) ? 16'h1AA : 16'h055);
      end
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
